mem_arbiter: RTL

Parametrised N-port memory arbiter that sits between the request sources (cartridge bus front end, USB FIFO bridge, future DMA/debug ports) and the single memory controller port. It replaces the fixed two-source cart/USB selection with a round-robin scheme over `NUM_PORTS` requesters. It carries per-port access width and issues single-cycle command pulses to memory. Optionally, it bounds read latency with a watchdog.

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-port memory arbiter issuing single-cycle command pulses
// Optional read watchdog and stale-return discard enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_W         = 26,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req_rd,
   input  logic [NUM_PORTS-1:0]          req_wr,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PORTS*2-1:0]        req_width,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wr_data,
   output logic [DATA_W-1:0]             rsp_rd_data,
   output logic [NUM_PORTS-1:0]          rsp_rd_valid,
   output logic [NUM_PORTS-1:0]          rsp_wr_ack,
   output logic [NUM_PORTS-1:0]          rsp_err,
   input  logic                          mem_rd_ready,
   input  logic                          mem_wr_ready,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [1:0]                    mem_data_width,
   output logic [DATA_W-1:0]             mem_wr_data,
   output logic                          mem_rd,
   output logic                          mem_wr,
   input  logic [DATA_W-1:0]             mem_rd_data,
   input  logic                          mem_rd_valid
);

   localparam int          IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_RESP} state_t;

   state_t                r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_last_grant, w_last_grant_nxt;
   logic [IDX_W-1:0]      r_grant;
   logic                  r_op_rd;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [1:0]            r_mem_width;
   logic [DATA_W-1:0]     r_mem_wr_data;
   logic                  r_mem_rd, w_mem_rd_nxt;
   logic                  r_mem_wr, w_mem_wr_nxt;
   logic [DATA_W-1:0]     r_rd_data, w_rd_data_nxt;
   logic [NUM_PORTS-1:0]  r_rd_valid, w_rd_valid_nxt;
   logic [NUM_PORTS-1:0]  r_wr_ack, w_wr_ack_nxt;
   logic [NUM_PORTS-1:0]  w_grant_oh;
   logic [NUM_PORTS-1:0]  w_can_rd;
   logic                  w_hit, w_hit_rd, w_latch;
   logic [IDX_W-1:0]      w_hit_idx, w_idx;
   logic                  w_stale;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_stale, w_stale_nxt;
   logic [NUM_PORTS-1:0]  r_err, w_err_nxt;

   assign w_stale = r_stale;
   assign rsp_err = r_err;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_stale          = 1'b0;
   assign rsp_err          = '0;
`endif

   // After a watchdog expiry reads are held back until the late return has drained.
   assign w_can_rd   = req_rd & {NUM_PORTS{~w_stale}};
   assign w_grant_oh = NUM_PORTS'(1) << r_grant;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_rd  = 1'b0;
      w_hit_idx = '0;
      w_idx     = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_idx = IDX_W'((int'(r_last_grant) + 1 + k) % NUM_PORTS);
         if (!w_hit && (w_can_rd[w_idx] || req_wr[w_idx])) begin
            w_hit     = 1'b1;
            w_hit_rd  = w_can_rd[w_idx];
            w_hit_idx = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_latch          = 1'b0;
      w_mem_rd_nxt     = 1'b0;
      w_mem_wr_nxt     = 1'b0;
      w_rd_valid_nxt   = '0;
      w_wr_ack_nxt     = '0;
      w_rd_data_nxt    = r_rd_data;
`ifdef MEM_ARB_TIMEOUT_EN
      w_err_nxt        = '0;
      w_cnt_nxt        = r_cnt;
      w_stale_nxt      = r_stale;
      if (r_stale && mem_rd_valid) begin
         w_stale_nxt = 1'b0;
      end
`endif
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               w_latch     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_op_rd && mem_rd_ready) begin
               w_mem_rd_nxt = 1'b1;
               w_state_nxt  = S_RD_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
               w_cnt_nxt    = '0;
`endif
            end else if (!r_op_rd && mem_wr_ready) begin
               w_mem_wr_nxt = 1'b1;
               w_wr_ack_nxt = w_grant_oh;
               w_state_nxt  = S_RESP;
            end
         end
         S_RD_WAIT: begin
            // The first RD_WAIT cycle carries the mem_rd pulse; returns count from the next one.
            if (!r_mem_rd) begin
               if (mem_rd_valid) begin
                  w_rd_data_nxt  = mem_rd_data;
                  w_rd_valid_nxt = w_grant_oh;
                  w_state_nxt    = S_RESP;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  w_rd_data_nxt  = TIMEOUT_DATA[DATA_W-1:0];
                  w_rd_valid_nxt = w_grant_oh;
                  w_err_nxt      = w_grant_oh;
                  w_stale_nxt    = 1'b1;
                  w_state_nxt    = S_RESP;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
`endif
            end
         end
         S_RESP: begin
            w_last_grant_nxt = r_grant;
            w_state_nxt      = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_last_grant  <= IDX_W'(NUM_PORTS - 1);
         r_grant       <= '0;
         r_op_rd       <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_width   <= '0;
         r_mem_wr_data <= '0;
         r_mem_rd      <= 1'b0;
         r_mem_wr      <= 1'b0;
         r_rd_data     <= '0;
         r_rd_valid    <= '0;
         r_wr_ack      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt         <= '0;
         r_stale       <= 1'b0;
         r_err         <= '0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_last_grant  <= w_last_grant_nxt;
         r_mem_rd      <= w_mem_rd_nxt;
         r_mem_wr      <= w_mem_wr_nxt;
         r_rd_data     <= w_rd_data_nxt;
         r_rd_valid    <= w_rd_valid_nxt;
         r_wr_ack      <= w_wr_ack_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt         <= w_cnt_nxt;
         r_stale       <= w_stale_nxt;
         r_err         <= w_err_nxt;
`endif
         if (w_latch) begin
            r_grant       <= w_hit_idx;
            r_op_rd       <= w_hit_rd;
            r_mem_addr    <= req_addr[w_hit_idx*ADDR_W +: ADDR_W];
            r_mem_width   <= req_width[w_hit_idx*2 +: 2];
            r_mem_wr_data <= req_wr_data[w_hit_idx*DATA_W +: DATA_W];
         end
      end
   end

   assign mem_addr       = r_mem_addr;
   assign mem_data_width = r_mem_width;
   assign mem_wr_data    = r_mem_wr_data;
   assign mem_rd         = r_mem_rd;
   assign mem_wr         = r_mem_wr;
   assign rsp_rd_data    = r_rd_data;
   assign rsp_rd_valid   = r_rd_valid;
   assign rsp_wr_ack     = r_wr_ack;

endmodule
